// File: rtl/floppy_track_multi.sv
// floppy_track_multi: per-drive whole-track cache loader sharing one SD block port via a round-robin arbiter.
// Optional write-protect input `wp` is enabled by defining FLOPPY_WP_EN.
module floppy_track_multi #(
    parameter int unsigned NUM_DRIVES        = 2,
    parameter int unsigned SECTORS_PER_TRACK = 13,
    parameter int unsigned TRACK_BITS        = 6,
    parameter int unsigned REL_BITS          = 4,
    parameter int unsigned DRV_BITS          = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    output logic [31:0]                      sd_lba,
    output logic [DRV_BITS-1:0]              sd_drive,
    output logic                             sd_rd,
    output logic                             sd_wr,
    input  logic                             sd_ack,
    input  logic [8:0]                       sd_buff_addr,
    input  logic                             sd_buff_wr,
    output logic [DRV_BITS+REL_BITS+8:0]     buf_addr,
    output logic                             buf_we,
    input  logic [NUM_DRIVES-1:0]            change,
    input  logic [NUM_DRIVES-1:0]            mount,
    input  logic [NUM_DRIVES*TRACK_BITS-1:0] track,
    input  logic [NUM_DRIVES-1:0]            active,
    input  logic [NUM_DRIVES-1:0]            ram_we,
`ifdef FLOPPY_WP_EN
    input  logic [NUM_DRIVES-1:0]            wp,
`endif
    output logic [NUM_DRIVES-1:0]            ready,
    output logic [NUM_DRIVES-1:0]            busy
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [TRACK_BITS-1:0]  r_cur_track [NUM_DRIVES];
    logic [NUM_DRIVES-1:0]  r_ready, r_dirty, r_old_change, r_fall_pend, r_busy;
    logic [REL_BITS-1:0]    r_rel;
    logic [31:0]            r_lba;
    logic [DRV_BITS-1:0]    r_drv, r_ptr;
    logic                   r_rd, r_wr, r_old_ack, r_abort;

    logic [TRACK_BITS-1:0]  w_trk [NUM_DRIVES];
    logic [NUM_DRIVES-1:0]  w_need, w_rise, w_fall, w_wp;
    logic [DRV_BITS-1:0]    w_win, w_sel;
    logic                   w_found, w_ack_fall, w_last, w_abort_now;
    logic                   w_start_read, w_start_write, w_next_sector, w_done;
    logic [31:0]            w_read_lba, w_write_lba;

`ifdef FLOPPY_WP_EN
    assign w_wp = wp;
`else
    assign w_wp = '0;
`endif

    assign w_rise      = change & ~r_old_change;
    assign w_fall      = ~change & r_old_change;
    assign w_ack_fall  = r_old_ack & ~sd_ack;
    assign w_last      = (r_rel == REL_BITS'(SECTORS_PER_TRACK - 1));
    assign w_abort_now = r_abort | w_rise[r_drv];
    assign w_sel       = (r_state == S_IDLE) ? w_win : r_drv;
    assign w_read_lba  = 32'(w_trk[w_sel]) * 32'(SECTORS_PER_TRACK);
    assign w_write_lba = 32'(r_cur_track[w_win]) * 32'(SECTORS_PER_TRACK);

    always_comb begin
        for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
            w_trk[i]  = track[i*TRACK_BITS +: TRACK_BITS];
            w_need[i] = r_ready[i] && ((r_cur_track[i] != w_trk[i]) || r_fall_pend[i] ||
                                       (r_dirty[i] && !active[i]));
        end
    end

    // Round-robin: first requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_DRIVES; k++) begin
            idx = (32'(r_ptr) + k) % NUM_DRIVES;
            if (!w_found && w_need[idx]) begin
                w_found = 1'b1;
                w_win   = DRV_BITS'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_read  = 1'b0;
        w_start_write = 1'b0;
        w_next_sector = 1'b0;
        w_done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (r_dirty[w_win] && (r_cur_track[w_win] != '1) && !w_wp[w_win]) begin
                        w_start_write = 1'b1;
                        w_state_nxt   = S_WRITE;
                    end else begin
                        w_start_read = 1'b1;
                        w_state_nxt  = S_READ;
                    end
                end
            end
            S_READ, S_WRITE: begin
                if (w_ack_fall) begin
                    if (w_abort_now) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (!w_last) begin
                        w_next_sector = 1'b1;
                    end else if (r_state == S_WRITE && r_cur_track[r_drv] != w_trk[r_drv]) begin
                        w_start_read = 1'b1;
                        w_state_nxt  = S_READ;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Per-drive bookkeeping; later statements take priority (change rise over everything).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready      <= '0;
            r_dirty      <= '0;
            r_old_change <= '0;
            r_fall_pend  <= '0;
            r_busy       <= '0;
            for (int unsigned i = 0; i < NUM_DRIVES; i++) r_cur_track[i] <= '1;
        end else begin
            r_old_change <= change;
            for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
                if (w_fall[i]) r_fall_pend[i] <= 1'b1;
                if (32'(w_sel) == i) begin
                    if (w_start_read) begin
                        r_cur_track[i] <= w_trk[i];
                        r_dirty[i]     <= 1'b0;
                        r_fall_pend[i] <= 1'b0;
                    end
                    if (w_start_write) r_dirty[i] <= 1'b0;
                end
                if (ram_we[i] && r_ready[i] && !w_wp[i]) r_dirty[i] <= 1'b1;
                if (w_rise[i]) begin
                    r_ready[i]     <= mount[i];
                    r_cur_track[i] <= '1;
                    r_dirty[i]     <= 1'b0;
                end
            end
            if (w_done) r_busy <= '0;
            else if (r_state == S_IDLE && w_found) r_busy[w_win] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lba     <= '0;
            r_rel     <= '0;
            r_drv     <= '0;
            r_ptr     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_old_ack <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_old_ack <= sd_ack;
            if (r_state == S_IDLE && w_found) begin
                r_drv <= w_win;
                r_ptr <= DRV_BITS'((32'(w_win) + 1) % NUM_DRIVES);
            end
            if (w_state_nxt == S_IDLE)                 r_abort <= 1'b0;
            else if (r_state != S_IDLE && w_rise[r_drv]) r_abort <= 1'b1;
            if (w_start_read) begin
                r_lba <= w_read_lba;
                r_rel <= '0;
                r_rd  <= 1'b1;
                r_wr  <= 1'b0;
            end else if (w_start_write) begin
                r_lba <= w_write_lba;
                r_rel <= '0;
                r_wr  <= 1'b1;
            end else if (w_next_sector) begin
                r_lba <= r_lba + 32'd1;
                r_rel <= r_rel + 1'b1;
                r_rd  <= (r_state == S_READ);
                r_wr  <= (r_state == S_WRITE);
            end else if (sd_ack) begin
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end
        end
    end

    assign sd_lba   = r_lba;
    assign sd_drive = r_drv;
    assign sd_rd    = r_rd;
    assign sd_wr    = r_wr;
    assign ready    = r_ready;
    assign busy     = r_busy;
    assign buf_addr = {r_drv, r_rel, sd_buff_addr};
    assign buf_we   = sd_buff_wr & sd_ack;

endmodule

// File: doc/floppy_track_multi.md
Name: floppy_track_multi

Overview:
Multi-drive successor to the single-drive Apple ][ track loader: caches one whole track per drive in a shared external track buffer RAM and moves sectors between that buffer and the SD block interface. Sectors per track, track-number width and drive count are parameters. Drives share one SD port through a round-robin arbiter. Runs entirely in the system controller domain; callers synchronise any core-domain signals before they reach this block.

Parameters:
NUM_DRIVES, 2, number of drives/images (1..4)
SECTORS_PER_TRACK, 13, 512-byte SD sectors per track (13 = 0x1A00 bytes)
TRACK_BITS, 6, width of each track number
REL_BITS, 4, sector-within-track counter width; must satisfy 2^REL_BITS >= SECTORS_PER_TRACK
DRV_BITS, 1, drive index width; must satisfy 2^DRV_BITS >= NUM_DRIVES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sd_lba  out  32  sector address within the selected image
sd_drive  out  DRV_BITS  image index for the current SD request
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  SD transfer acknowledge
sd_buff_addr  in  9  byte offset inside the current sector
sd_buff_wr  in  1  SD byte write strobe
buf_addr  out  DRV_BITS+REL_BITS+9  track buffer port address {sd_drive, rel, sd_buff_addr}
buf_we  out  1  track buffer write enable = sd_buff_wr & sd_ack
change  in  NUM_DRIVES  per-drive image change pulse/level
mount  in  NUM_DRIVES  per-drive image present
track  in  NUM_DRIVES*TRACK_BITS  requested track per drive; drive i uses slice [i*TRACK_BITS +: TRACK_BITS]
active  in  NUM_DRIVES  drive motor on
ram_we  in  NUM_DRIVES  core write into drive i's track buffer region
ready  out  NUM_DRIVES  drive has a mounted image
busy  out  NUM_DRIVES  drive's track is being transferred

Behaviour:
- Per-drive state: ready, cur_track (all-ones = invalid), dirty, change history (old_change).
- Reset (reset_n low, asynchronous): sd_rd=0, sd_wr=0, sd_lba=0, sd_drive=0, ready=0, busy=0, dirty=0, cur_track=all-ones, FSM=IDLE, arbiter pointer=0.
- Change handling: rising edge of change[i] sets ready[i]=mount[i], cur_track[i]=invalid, dirty[i]=0. A falling edge of change[i] forces a reload on drive i.
- Dirty: ram_we[i] && ready[i] sets dirty[i] on any cycle, including while a write-back is in progress.
- A drive needs service when ready[i] && !busy and at least one of:
  - cur_track != track[i]
  - falling edge of change[i] pending
  - dirty[i] && !active[i]
- FSM states:
  - IDLE: round-robin arbiter picks the lowest index >= pointer that needs service, wrapping around. Pointer is set to winner+1 mod NUM_DRIVES. busy[w]=1.
    - If dirty[w] and cur_track valid: go to WRITE. Clear dirty[w], set lba=cur_track*SPT, rel=0, sd_wr=1.
    - Otherwise: go to READ. Set cur_track=track[w], lba=track[w]*SPT, rel=0, sd_rd=1, dirty[w]=0.
  - WRITE / READ:
    - sd_rd/sd_wr drop on the first cycle sd_ack is high.
    - On the sd_ack falling edge with rel != SPT-1: rel+1, lba+1, reissue the same request in the same cycle.
    - On the sd_ack falling edge with rel == SPT-1:
      - WRITE with cur_track != track[w]: go to READ of the new track (as in IDLE).
      - Otherwise: busy[w]=0, return to IDLE.
- Arithmetic: lba = track*SPT + rel, zero-extended to 32 bits. No overflow is possible at default widths.
- Rising edge of change[w] mid-transfer: the in-flight sector completes. At its ack falling edge no further request is issued. busy[w]=0, FSM goes to IDLE, and drive state is reset as above.
- A track change during a READ is ignored until completion; it is then serviced as a new request.
- Only one SD request is outstanding at any time. sd_drive is held constant for a whole service.

Optional Feature:
FLOPPY_WP_EN: adds input wp (NUM_DRIVES, write-protect). When wp[i]=1, ram_we[i] never sets dirty[i], and an existing dirty[i] is discarded at the next service (READ only, no WRITE). Without the macro there is no wp port and the behaviour is as above.

Test Plan:
- Mount drive 0 (change pulse, mount=1), track=3 -> ready[0]=1; 13 sd_rd requests, sd_lba 39..51, sd_drive=0; busy[0] falls after the 13th ack.
- Drive 0 dirty on track 3, track changes to 4 -> 13 sd_wr requests at LBA 39..51, then 13 sd_rd requests at LBA 52..64; dirty=0.
- Drive 0 dirty, active 1->0, track unchanged -> 13 writes at LBA 39..51 only; ram_we during the write-back leaves dirty=1 at completion.
- Both drives request in the same cycle with pointer=0 -> drive 0 serviced first, then drive 1, with sd_drive switching only between services.
- Change rising edge on drive 1 during its 5th sector -> no 6th request; busy[1]=0; cur_track[1]=0x3F; reload follows on change falling edge.
- FLOPPY_WP_EN, wp[0]=1, ram_we pulses, active drops -> no sd_wr issued; a track change produces a read only.
